// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter
//   Shares one WIDTH-bit adder among NUM_REQ requesters. A round-robin arbiter
//   grants one valid request per cycle. The registered sum/carry is tagged with
//   the requester index and held in a one-entry valid/ready output buffer.
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-low
//   io_req_valid   per-requester request valid
//   io_req_ready   per-requester accept (one-hot or zero)
//   io_req_a/b     operands, requester i at [i*WIDTH +: WIDTH]
//   io_resp_valid  buffer holds a result
//   io_resp_ready  consumer accepts the result
//   io_resp_sum    (a+b) mod 2^WIDTH
//   io_resp_carry  carry-out of a+b
//   io_resp_id     index of the requester owning the result
module adder_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       io_req_valid,
  output logic [NUM_REQ-1:0]       io_req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] io_req_a,
  input  logic [NUM_REQ*WIDTH-1:0] io_req_b,
  output logic                     io_resp_valid,
  input  logic                     io_resp_ready,
  output logic [WIDTH-1:0]         io_resp_sum,
  output logic                     io_resp_carry,
  output logic [ID_W-1:0]          io_resp_id
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state_q;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] cand;
  logic            grant_found;
  logic            can_accept;
  logic            transfer;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;

  // Search starts at the pointer and wraps modulo NUM_REQ; first valid wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!grant_found && io_req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // Draining and refilling in the same cycle keeps throughput at one per cycle.
  assign can_accept = (state_q == EMPTY) || io_resp_ready;
  assign transfer   = reset && can_accept && grant_found;

  always_comb begin
    io_req_ready = '0;
    if (transfer) begin
      io_req_ready[grant_id] = 1'b1;
    end
  end

  assign a_sel = io_req_a[int'(grant_id)*WIDTH +: WIDTH];
  assign b_sel = io_req_b[int'(grant_id)*WIDTH +: WIDTH];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= EMPTY;
      ptr_q         <= '0;
      io_resp_sum   <= '0;
      io_resp_carry <= 1'b0;
      io_resp_id    <= '0;
    end else if (transfer) begin
      state_q                      <= FULL;
      {io_resp_carry, io_resp_sum} <= {1'b0, a_sel} + {1'b0, b_sel};
      io_resp_id                   <= grant_id;
      ptr_q <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end else if (state_q == FULL && io_resp_ready) begin
      state_q <= EMPTY;
    end
  end

  assign io_resp_valid = (state_q == FULL);

endmodule

// File: tb/tb_adder_rr_arbiter.sv
module tb_adder_rr_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  io_req_valid;
  logic [3:0]  io_req_ready;
  logic [15:0] io_req_a;
  logic [15:0] io_req_b;
  logic        io_resp_valid;
  logic        io_resp_ready;
  logic [3:0]  io_resp_sum;
  logic        io_resp_carry;
  logic [1:0]  io_resp_id;

  int n_cmp = 0;
  int n_bad = 0;

  adder_rr_arbiter #(
    .NUM_REQ(4),
    .WIDTH(4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_req_valid (io_req_valid),
    .io_req_ready (io_req_ready),
    .io_req_a     (io_req_a),
    .io_req_b     (io_req_b),
    .io_resp_valid(io_resp_valid),
    .io_resp_ready(io_resp_ready),
    .io_resp_sum  (io_resp_sum),
    .io_resp_carry(io_resp_carry),
    .io_resp_id   (io_resp_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b);
    io_req_a[i*4 +: 4] = a;
    io_req_b[i*4 +: 4] = b;
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    io_req_valid  = 4'hF;
    io_resp_ready = 1'b1;
    io_req_a      = 16'h1234;
    io_req_b      = 16'h5678;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      n_cmp++;
      if (io_req_ready !== 4'b0000) begin
        n_bad++; $display("FAIL reset_ready cycle %0d: got %b want 0000", c, io_req_ready);
      end
      n_cmp++;
      if (io_resp_valid !== 1'b0) begin
        n_bad++; $display("FAIL reset_valid cycle %0d: got %b want 0", c, io_resp_valid);
      end
      n_cmp++;
      if ({io_resp_carry, io_resp_sum, io_resp_id} !== 7'd0) begin
        n_bad++; $display("FAIL reset_data cycle %0d: got c=%b s=%0d id=%0d want 0/0/0",
                          c, io_resp_carry, io_resp_sum, io_resp_id);
      end
    end
    reset        = 1'b1;
    io_req_valid = 4'b0000;
  endtask

  task automatic test_single();
    io_req_valid  = 4'b0100;
    io_resp_ready = 1'b1;
    set_ops(2, 4'd3, 4'd4);
    #1;
    n_cmp++;
    if (io_req_ready !== 4'b0100) begin
      n_bad++; $display("FAIL single_ready: got %b want 0100", io_req_ready);
    end
    @(negedge clock);
    io_req_valid = 4'b0000;
    n_cmp++;
    if ({io_resp_valid, io_resp_carry, io_resp_sum, io_resp_id} !== {1'b1, 1'b0, 4'd7, 2'd2}) begin
      n_bad++; $display("FAIL single_resp: got v=%b c=%b s=%0d id=%0d want 1/0/7/2",
                        io_resp_valid, io_resp_carry, io_resp_sum, io_resp_id);
    end
    @(negedge clock);
    n_cmp++;
    if (io_resp_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_drain: got %b want 0", io_resp_valid);
    end
  endtask

  // Pointer is 3 on entry; requester 0 is still found via wrap-around.
  task automatic test_overflow();
    io_req_valid = 4'b0001;
    set_ops(0, 4'd15, 4'd15);
    #1;
    n_cmp++;
    if (io_req_ready !== 4'b0001) begin
      n_bad++; $display("FAIL ovf_ready: got %b want 0001", io_req_ready);
    end
    @(negedge clock);
    n_cmp++;
    if ({io_resp_valid, io_resp_carry, io_resp_sum, io_resp_id} !== {1'b1, 1'b1, 4'd14, 2'd0}) begin
      n_bad++; $display("FAIL ovf_15p15: got v=%b c=%b s=%0d id=%0d want 1/1/14/0",
                        io_resp_valid, io_resp_carry, io_resp_sum, io_resp_id);
    end
    set_ops(0, 4'd8, 4'd8);
    @(negedge clock);
    io_req_valid = 4'b0000;
    n_cmp++;
    if ({io_resp_valid, io_resp_carry, io_resp_sum, io_resp_id} !== {1'b1, 1'b1, 4'd0, 2'd0}) begin
      n_bad++; $display("FAIL ovf_8p8: got v=%b c=%b s=%0d id=%0d want 1/1/0/0",
                        io_resp_valid, io_resp_carry, io_resp_sum, io_resp_id);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_ready;
    logic [3:0] exp_sum;
    // Reset once so the rotation starts from pointer 0.
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) set_ops(i, 4'(i), 4'(i + 1));
    io_req_valid  = 4'hF;
    io_resp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_ready = 4'b0001 << (k % 4);
      exp_sum   = 4'(2 * (k % 4) + 1);
      #1;
      n_cmp++;
      if (io_req_ready !== exp_ready) begin
        n_bad++; $display("FAIL rot_ready[%0d]: got %b want %b", k, io_req_ready, exp_ready);
      end
      @(negedge clock);
      n_cmp++;
      if ({io_resp_valid, io_resp_id, io_resp_sum} !== {1'b1, 2'(k % 4), exp_sum}) begin
        n_bad++; $display("FAIL rot_resp[%0d]: got v=%b id=%0d s=%0d want 1/%0d/%0d",
                          k, io_resp_valid, io_resp_id, io_resp_sum, k % 4, exp_sum);
      end
    end
    io_req_valid = 4'b0000;
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    io_req_valid = 4'b0010;
    set_ops(1, 4'd2, 4'd3);
    #1;
    n_cmp++;
    if (io_req_ready !== 4'b0010) begin
      n_bad++; $display("FAIL bp_fill_ready: got %b want 0010", io_req_ready);
    end
    @(negedge clock);
    io_resp_ready = 1'b0;
    io_req_valid  = 4'b1000;
    set_ops(3, 4'd6, 4'd7);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (io_req_ready !== 4'b0000) begin
        n_bad++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, io_req_ready);
      end
      @(negedge clock);
      n_cmp++;
      if ({io_resp_valid, io_resp_carry, io_resp_sum, io_resp_id} !== {1'b1, 1'b0, 4'd5, 2'd1}) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got v=%b c=%b s=%0d id=%0d want 1/0/5/1",
                          c, io_resp_valid, io_resp_carry, io_resp_sum, io_resp_id);
      end
    end
    io_resp_ready = 1'b1;
    #1;
    n_cmp++;
    if (io_req_ready !== 4'b1000) begin
      n_bad++; $display("FAIL bp_release_ready: got %b want 1000", io_req_ready);
    end
    @(negedge clock);
    io_req_valid = 4'b0000;
    n_cmp++;
    if ({io_resp_valid, io_resp_carry, io_resp_sum, io_resp_id} !== {1'b1, 1'b0, 4'd13, 2'd3}) begin
      n_bad++; $display("FAIL bp_release_resp: got v=%b c=%b s=%0d id=%0d want 1/0/13/3",
                        io_resp_valid, io_resp_carry, io_resp_sum, io_resp_id);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_midop();
    // Pointer is 0; serving requester 1 leaves it at 2 with the buffer held full.
    io_req_valid  = 4'b0010;
    io_resp_ready = 1'b0;
    set_ops(1, 4'd1, 4'd1);
    @(negedge clock);
    reset         = 1'b0;
    io_req_valid  = 4'b0101;
    io_resp_ready = 1'b1;
    set_ops(0, 4'd5, 4'd9);
    set_ops(2, 4'd10, 4'd11);
    #1;
    n_cmp++;
    if (io_req_ready !== 4'b0000) begin
      n_bad++; $display("FAIL midrst_ready: got %b want 0000", io_req_ready);
    end
    @(negedge clock);
    n_cmp++;
    if ({io_resp_valid, io_resp_carry, io_resp_sum, io_resp_id} !== 8'd0) begin
      n_bad++; $display("FAIL midrst_clear: got v=%b c=%b s=%0d id=%0d want 0/0/0/0",
                        io_resp_valid, io_resp_carry, io_resp_sum, io_resp_id);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (io_req_ready !== 4'b0001) begin
      n_bad++; $display("FAIL midrst_first_ready: got %b want 0001", io_req_ready);
    end
    @(negedge clock);
    n_cmp++;
    if ({io_resp_valid, io_resp_carry, io_resp_sum, io_resp_id} !== {1'b1, 1'b0, 4'd14, 2'd0}) begin
      n_bad++; $display("FAIL midrst_first_resp: got v=%b c=%b s=%0d id=%0d want 1/0/14/0",
                        io_resp_valid, io_resp_carry, io_resp_sum, io_resp_id);
    end
    #1;
    n_cmp++;
    if (io_req_ready !== 4'b0100) begin
      n_bad++; $display("FAIL midrst_second_ready: got %b want 0100", io_req_ready);
    end
    @(negedge clock);
    io_req_valid = 4'b0000;
    n_cmp++;
    if ({io_resp_valid, io_resp_carry, io_resp_sum, io_resp_id} !== {1'b1, 1'b1, 4'd5, 2'd2}) begin
      n_bad++; $display("FAIL midrst_second_resp: got v=%b c=%b s=%0d id=%0d want 1/1/5/2",
                        io_resp_valid, io_resp_carry, io_resp_sum, io_resp_id);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_rotation();
    test_backpressure();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
